// File: rtl/riscv_pkg.sv
// Shared types for the core's memory-side blocks.
//   arb_owner_t    : owner tag of a memory access (none, fetch port, load/store port)
//   ARB_RESET_LAST : last-granted value after reset, so the fetch port wins the first tie
package riscv_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } arb_owner_t;

  localparam arb_owner_t ARB_RESET_LAST = OWN_M1;

endpackage

// File: rtl/mem_arbiter_rr_picker2.sv
// rr_picker2: combinational two-input round-robin select.
//   req0_i, req1_i : request lines
//   last_gnt_i     : master granted most recently (OWN_M0 / OWN_M1)
//   gnt0_o, gnt1_o : one-hot (or zero) grant
// On a tie the master that was not granted last wins.
module rr_picker2
  import riscv_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  arb_owner_t last_gnt_i,
  output logic       gnt0_o,
  output logic       gnt1_o
);

  always_comb begin
    gnt0_o = req0_i & (~req1_i | (last_gnt_i != OWN_M0));
    gnt1_o = req1_i & (~req0_i | (last_gnt_i == OWN_M0));
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous RAM between the
// instruction-fetch port (m0) and the load/store port (m1).
//   clk, rst               : clock, asynchronous active-high reset
//   m0_req/addr/gnt        : fetch request handshake (reads only)
//   m0_rvalid/rdata        : fetch data, one cycle after m0_gnt
//   m1_req/we/be/addr/wdata: load/store request, m1_gnt accepts it
//   m1_rvalid/rdata        : load data, one cycle after m1_gnt on a load
//   mem_*                  : memory drive; mem_rdata valid the cycle after a read
// Grant and memory drive are combinational from the requests; the read
// return path is a one-entry owner register.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_owner_t last_gnt_q, last_gnt_d;
  arb_owner_t rd_owner_q, rd_owner_d;
  logic       pick0, pick1;

  rr_picker2 u_picker (
    .req0_i     (m0_req),
    .req1_i     (m1_req),
    .last_gnt_i (last_gnt_q),
    .gnt0_o     (pick0),
    .gnt1_o     (pick1)
  );

  // Grants are held off while reset is asserted so every output sits at its
  // reset value; a request held across release is arbitrated on the first
  // cycle afterwards.
  assign m0_gnt = pick0 & ~rst;
  assign m1_gnt = pick1 & ~rst;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = m0_addr;
    end else if (m1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_be    = m1_be;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    rd_owner_d = OWN_NONE;
    if (m0_gnt) begin
      last_gnt_d = OWN_M0;
      rd_owner_d = OWN_M0;
    end else if (m1_gnt) begin
      last_gnt_d = OWN_M1;
      rd_owner_d = m1_we ? OWN_NONE : OWN_M1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= ARB_RESET_LAST;
      rd_owner_q <= OWN_NONE;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign m0_rvalid = (rd_owner_q == OWN_M0);
  assign m1_rvalid = (rd_owner_q == OWN_M1);

  // Both ports see the raw RAM output; only the matching rvalid qualifies it.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_be     (m1_be),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    arb_owner_t  own;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   last_was_m0 = 1'b0;   // model of who was granted most recently
  int   g0_seen = 0;
  int   g1_seen = 0;

  // RAM contents as seen by the bench.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // One clock cycle: entered just after a falling edge, drives the request
  // inputs, checks the combinational grant/memory drive, pushes the expected
  // read return, then acts as the RAM and checks the return after the edge.
  task automatic run_cycle(input bit r0, input logic [31:0] a0, input bit r1,
                           input bit we, input logic [3:0] be,
                           input logic [31:0] a1, input logic [31:0] wd,
                           input string tag);
    bit          eg0, eg1, rd_pend;
    logic [31:0] rd_addr, ea;
    logic [3:0]  ebe;
    bit          ewe, een;
    exp_t        e;
    m0_req = r0; m0_addr = a0;
    m1_req = r1; m1_we = we; m1_be = be; m1_addr = a1; m1_wdata = wd;
    if (r0 && r1) begin
      eg0 = !last_was_m0;
      eg1 = last_was_m0;
    end else begin
      eg0 = r0;
      eg1 = r1;
    end
    een = eg0 || eg1;
    ea  = eg0 ? a0 : (eg1 ? a1 : 32'h0);
    ewe = eg1 && we;
    ebe = eg0 ? 4'hF : (eg1 ? be : 4'h0);
    #1;
    n_cmp++;
    if (m0_gnt !== eg0 || m1_gnt !== eg1) begin
      n_err++;
      $display("FAIL %s.gnt: got m0=%b m1=%b required m0=%b m1=%b", tag, m0_gnt, m1_gnt, eg0, eg1);
    end
    n_cmp++;
    if (mem_en !== een || mem_addr !== ea || mem_we !== ewe || mem_be !== ebe) begin
      n_err++;
      $display("FAIL %s.mem: got en=%b addr=%h we=%b be=%b required en=%b addr=%h we=%b be=%b",
               tag, mem_en, mem_addr, mem_we, mem_be, een, ea, ewe, ebe);
    end
    if (eg1 && we) begin
      n_cmp++;
      if (mem_wdata !== wd) begin
        n_err++;
        $display("FAIL %s.wdata: got %h required %h", tag, mem_wdata, wd);
      end
    end
    if (m0_gnt === 1'b1) g0_seen++;
    if (m1_gnt === 1'b1) g1_seen++;
    e.tag  = tag;
    e.own  = eg0 ? OWN_M0 : ((eg1 && !we) ? OWN_M1 : OWN_NONE);
    e.data = memfn(ea);
    sb.push_back(e);
    if (eg0) last_was_m0 = 1'b1;
    else if (eg1) last_was_m0 = 1'b0;
    rd_pend = mem_en && !mem_we;
    rd_addr = mem_addr;
    @(posedge clk);
    #1 mem_rdata = rd_pend ? memfn(rd_addr) : 32'h0;
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (m0_rvalid !== (e.own == OWN_M0) || m1_rvalid !== (e.own == OWN_M1)) begin
      n_err++;
      $display("FAIL %s.rvalid: got m0=%b m1=%b required owner %s", e.tag, m0_rvalid, m1_rvalid, e.own.name());
    end
    if (e.own == OWN_M0) begin
      n_cmp++;
      if (m0_rdata !== e.data) begin
        n_err++;
        $display("FAIL %s.m0_rdata: got %h required %h", e.tag, m0_rdata, e.data);
      end
    end
    if (e.own == OWN_M1) begin
      n_cmp++;
      if (m1_rdata !== e.data) begin
        n_err++;
        $display("FAIL %s.m1_rdata: got %h required %h", e.tag, m1_rdata, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_addr = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_was_m0 = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_rdata = '0;
    idle_inputs();
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h44; m1_addr = 32'h88;
    m1_we = 1'b1; m1_be = 4'hF; m1_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we} !== 6'b0 ||
        mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset.outputs: got gnt=%b%b rv=%b%b en=%b we=%b be=%b addr=%h wd=%h required all zero",
               m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
    end
    idle_inputs();
    rst = 1'b0;
    last_was_m0 = 1'b0;
  endtask

  task automatic test_fetch();
    run_cycle(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "fetch");
    run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "fetch_drain");
  endtask

  task automatic test_tie();
    do_reset();
    run_cycle(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, "tie_c1");
    run_cycle(1'b1, 32'h104, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, "tie_c2");
    run_cycle(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "tie_c3");
  endtask

  task automatic test_store();
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h0000_0041, 32'h0000_AB00, "store");
    run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "store_after");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, a1;
    a0 = 32'h1000;
    a1 = 32'h2003;
    g0_seen = 0;
    g1_seen = 0;
    for (int i = 0; i < 8; i++) begin
      bit g0;
      g0 = !last_was_m0;
      run_cycle(1'b1, a0, 1'b1, 1'b0, 4'hF, a1, 32'h0, $sformatf("contend%0d", i));
      if (g0) a0 = a0 + 32'h4;
      else    a1 = a1 + 32'h10;
    end
    n_cmp++;
    if (g0_seen != 4 || g1_seen != 4) begin
      n_err++;
      $display("FAIL contend.count: got m0=%0d m1=%0d required 4/4", g0_seen, g1_seen);
    end
    run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "contend_drain");
  endtask

  task automatic test_reset_mid_read();
    m0_req = 1'b1; m0_addr = 32'h300;
    #1;
    n_cmp++;
    if (m0_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL midrst.gnt: got %b required 1", m0_gnt);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we} !== 6'b0 ||
        mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL midrst.outputs: got gnt=%b%b rv=%b%b en=%b we=%b be=%b addr=%h required all zero",
               m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, mem_be, mem_addr);
    end
    @(posedge clk);
    #1 mem_rdata = memfn(32'h300);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst.rvalid: got m0=%b m1=%b required 0/0", m0_rvalid, m1_rvalid);
    end
    @(negedge clk);
    // Both requests held across release: last_gnt back at M1, so m0 wins.
    m1_req = 1'b1; m1_addr = 32'h400; m1_we = 1'b0; m1_be = 4'hF;
    rst = 1'b0;
    last_was_m0 = 1'b0;
    sb.delete();
    run_cycle(1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, "postrst_c1");
    run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0, "postrst_c2");
  endtask

  task automatic test_idle();
    run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "idle1");
    run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "idle2");
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_fetch();
    test_tie();
    test_store();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
